// File: rtl/key_debounce.sv
// 8-bit key vector debouncer with a one-deep event slot and sticky overflow.
// Define KEY_DEBOUNCE_SYNC2_EN for a two-flop input synchronizer (+1 cycle).
module key_debounce #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_in,
  input  logic       key_ready,
  output logic [7:0] key_out,
  output logic       key_valid,
  output logic [7:0] key_state,
  output logic       key_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic {EMPTY, FULL} slot_e;

  logic [7:0]       s_q;
  logic [7:0]       cand_q, cand_d;
  logic [7:0]       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             evt;
  slot_e            slot_q, slot_d;

`ifdef KEY_DEBOUNCE_SYNC2_EN
  logic [7:0] s1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s_q  <= '0;
    end else begin
      s1_q <= key_in;
      s_q  <= s1_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
    end else begin
      s_q <= key_in;
    end
  end
`endif

  // Whole vector is one unit: any change restarts the count.
  always_comb begin
    cand_d = cand_q;
    st_d   = st_q;
    cnt_d  = cnt_q;
    evt    = 1'b0;
    if (s_q != cand_q) begin
      cand_d = s_q;
      cnt_d  = '0;
    end else if (cand_q == st_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      st_d  = cand_q;
      cnt_d = '0;
      evt   = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= '0;
      st_q   <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cand_q <= cand_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= EMPTY;
    end else begin
      slot_q <= slot_d;
    end
  end

  always_comb begin
    slot_d = slot_q;
    out_d  = out_q;
    ovf_d  = ovf_q;
    case (slot_q)
      EMPTY: begin
        if (evt) begin
          slot_d = FULL;
          out_d  = cand_q;
        end
      end
      FULL: begin
        if (evt && key_ready) begin
          out_d = cand_q;
        end else if (evt) begin
          ovf_d = 1'b1;
        end else if (key_ready) begin
          slot_d = EMPTY;
        end
      end
      default: slot_d = EMPTY;
    endcase
  end

  always_comb begin
    key_valid = (slot_q == FULL);
    key_out   = out_q;
    key_state = st_q;
    key_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with DEB_CYCLES=4.
module tb_key_debounce;

  localparam int DEB = 4;
`ifdef KEY_DEBOUNCE_SYNC2_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key_in = 8'h00;
  logic       key_ready = 1'b1;
  logic [7:0] key_out;
  logic       key_valid;
  logic [7:0] key_state;
  logic       key_ovf;

  key_debounce #(.DEB_CYCLES(DEB), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_ready(key_ready),
    .key_out(key_out), .key_valid(key_valid),
    .key_state(key_state), .key_ovf(key_ovf)
  );

  always #5 clk = ~clk;

  int ecount = 0;
  always @(posedge clk) ecount++;

  typedef struct {
    logic [7:0] v;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  int nvec = 0;
  int nerr = 0;

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on the negedge where key_in changes; dc=1 means timing unchecked.
  task automatic push(logic [7:0] v, bit dc);
    exp_t e;
    e.v   = v;
    e.cyc = dc ? -1 : ecount + 1 + DEB + L;
    sb.push_back(e);
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (key_valid && key_ready) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_event: got %h at edge %0d want none",
                 key_out, ecount);
      end else begin
        e = sb.pop_front();
        if (key_out !== e.v) begin
          nerr++;
          $display("FAIL event_value: got %h want %h", key_out, e.v);
        end
        if (e.cyc >= 0) begin
          nvec++;
          if (ecount != e.cyc) begin
            nerr++;
            $display("FAIL event_edge: got %0d want %0d", ecount, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    step(3);
    check("rst_out", key_out, 8'h00);
    check("rst_valid", 8'(key_valid), 8'h00);
    check("rst_state", key_state, 8'h00);
    check("rst_ovf", 8'(key_ovf), 8'h00);
    rst = 1'b0;
    step(2);

    key_in = 8'h08;
    push(8'h08, 1'b0);
    step(10);
    check("step_state", key_state, 8'h08);
    check("step_pulse", 8'(key_valid), 8'h00);
    key_in = 8'h00;
    push(8'h00, 1'b0);
    step(10);
    check("release_state", key_state, 8'h00);

    key_in = 8'h04;
    step(2);
    key_in = 8'h00;
    step(2);
    key_in = 8'h04;
    push(8'h04, 1'b0);
    step(10);
    check("bounce_state", key_state, 8'h04);
    key_in = 8'h00;
    push(8'h00, 1'b0);
    step(10);

    key_in = 8'h02;
    step(3);
    key_in = 8'h00;
    step(12);
    check("glitch_state", key_state, 8'h00);
    check("glitch_valid", 8'(key_valid), 8'h00);

    key_ready = 1'b0;
    key_in = 8'h01;
    push(8'h01, 1'b1);
    step(10);
    check("hold_valid", 8'(key_valid), 8'h01);
    check("hold_out", key_out, 8'h01);
    key_in = 8'h00;
    step(10);
    check("drop_ovf", 8'(key_ovf), 8'h01);
    check("drop_out", key_out, 8'h01);
    check("drop_state", key_state, 8'h00);
    key_ready = 1'b1;
    step(3);
    check("hs_valid", 8'(key_valid), 8'h00);
    check("ovf_sticky", 8'(key_ovf), 8'h01);

    key_in = 8'h03;
    step(L + 3);
    rst = 1'b1;
    step(2);
    check("midrst_out", key_out, 8'h00);
    check("midrst_valid", 8'(key_valid), 8'h00);
    check("midrst_state", key_state, 8'h00);
    check("midrst_ovf", 8'(key_ovf), 8'h00);
    rst = 1'b0;
    push(8'h03, 1'b0);
    step(10);
    check("post_rst_state", key_state, 8'h03);
    step(2);

    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL missing_events: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
